// File: rtl/seq_div32_if.sv
// Request/result bundle for the 32-bit sequential divider.
// The master side issues start with operands; the slave side returns
// busy/done and the registered results.
interface seq_div32_if;
  logic        start;
  logic        sign;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  modport master (
    output start, sign, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, sign, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );
endinterface

// File: rtl/seq_div32.sv
// 32-bit restoring divider, one quotient bit per clock.
// Signed mode divides magnitudes and fixes the signs when the result is
// registered; a zero divisor short-circuits straight to DONE.
module seq_div32 (
  input  logic         clk,
  input  logic         rst_n,
  seq_div32_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] dvd_q, dvd_d;        // dividend magnitude, quotient bits shift in at LSB
  logic [31:0] dvs_q, dvs_d;        // divisor magnitude
  logic [31:0] rem_q, rem_d;        // partial remainder
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] quotient_q, quotient_d;
  logic [31:0] remainder_q, remainder_d;
  logic        div_zero_q, div_zero_d;

  // One restoring step. The shifted remainder keeps its carry-out as bit 32
  // so divisors above 2^31 still divide correctly; a non-negative
  // difference always fits in 32 bits because it is below the divisor.
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        step_ok;
  logic [31:0] rem_step;
  logic [31:0] quo_step;
  logic        a_neg;
  logic        b_neg;

  assign shifted  = {rem_q, dvd_q[31]};
  assign diff     = shifted - {1'b0, dvs_q};
  assign step_ok  = ~diff[32];
  assign rem_step = step_ok ? diff[31:0] : shifted[31:0];
  assign quo_step = {dvd_q[30:0], step_ok};

  assign a_neg = bus.sign & bus.dividend[31];
  assign b_neg = bus.sign & bus.divisor[31];

  // Next-state, datapath and result register computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dvd_d     = a_neg ? (32'd0 - bus.dividend) : bus.dividend;
          dvs_d     = b_neg ? (32'd0 - bus.divisor) : bus.divisor;
          rem_d     = 32'd0;
          cnt_d     = 6'd0;
          if (bus.divisor == 32'd0) begin
            quotient_d  = 32'hFFFF_FFFF;
            remainder_d = bus.dividend;
            div_zero_d  = 1'b1;
            state_d     = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        dvd_d = quo_step;
        rem_d = rem_step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          quotient_d  = neg_quo_q ? (32'd0 - quo_step) : quo_step;
          remainder_d = neg_rem_q ? (32'd0 - rem_step) : rem_step;
          div_zero_d  = 1'b0;
          state_d     = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 6'd0;
      dvd_q       <= 32'd0;
      dvs_q       <= 32'd0;
      rem_q       <= 32'd0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= 32'd0;
      remainder_q <= 32'd0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_div32.sv
// Testbench for seq_div32: vector table, hand-written corner sequences and
// random operations checked against an arithmetic reference model.
module tb_seq_div32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_div32_if bus();

  seq_div32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero in signed mode.
  function automatic void ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz);
    longint sa;
    longint sb;
    if (b == 32'd0) begin
      q  = 32'hFFFF_FFFF;
      r  = a;
      dz = 1'b1;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
      dz = 1'b0;
    end else begin
      q  = a / b;
      r  = a % b;
      dz = 1'b0;
    end
  endfunction

  // Issue one divide, scramble inputs after acceptance, check latency,
  // results, single-cycle done and result hold.
  task automatic do_div(input string tag, input bit s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edz);
    int lat;
    @(negedge clk);
    bus.sign     = s;
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.sign     = 1'($urandom);
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
    chk({tag, " busy_after_start"}, {31'd0, bus.busy}, 32'd1);
    lat = 0;
    while (!bus.done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), (b == 32'd0) ? 32'd0 : 32'd32);
    chk({tag, " quotient"}, bus.quotient, eq);
    chk({tag, " remainder"}, bus.remainder, er);
    chk({tag, " div_zero"}, {31'd0, bus.div_zero}, {31'd0, edz});
    $display("op %s: sign=%0d %h / %h -> q=%h r=%h dz=%0d lat=%0d",
             tag, s, a, b, bus.quotient, bus.remainder, bus.div_zero, lat);
    @(posedge clk);
    #1;
    chk({tag, " done_single"}, {31'd0, bus.done}, 32'd0);
    chk({tag, " idle_after"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, " hold_q"}, bus.quotient, eq);
  endtask

  task automatic wait_done(input int limit, input string tag);
    int n;
    n = 0;
    while (!bus.done && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.done) chk({tag, " done_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    logic [31:0] eq, er;
    logic        edz;
    int          e0, t1, t2, done_cnt;
    bit          rs;
    logic [31:0] ra, rb;
    int          mode;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    vecs[2]  = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          1'b0};
    vecs[3]  = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
    vecs[4]  = '{1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[5]  = '{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
    vecs[6]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    vecs[7]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
    vecs[8]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0};
    vecs[9]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          32'd1,          1'b0};
    vecs[10] = '{1'b0, 32'd0,          32'd3,          32'd0,          32'd0,          1'b0};
    vecs[11] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};

    bus.start    = 1'b0;
    bus.sign     = 1'b0;
    bus.dividend = 32'd0;
    bus.divisor  = 32'd0;

    // Asynchronous reset, checked before the first clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset done", {31'd0, bus.done}, 32'd0);
    chk("reset quotient", bus.quotient, 32'd0);
    chk("reset remainder", bus.remainder, 32'd0);
    chk("reset div_zero", {31'd0, bus.div_zero}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table.
    for (int i = 0; i < 12; i++) begin
      do_div($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b,
             vecs[i].q, vecs[i].r, vecs[i].dz);
    end

    // Start pulse during RUN must be ignored.
    @(negedge clk);
    bus.sign = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    e0 = cyc;
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.dividend = 32'd9; bus.divisor = 32'd3; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(100, "ignore");
    chk("ignore latency", 32'(cyc - e0), 32'd32);
    chk("ignore quotient", bus.quotient, 32'd14);
    chk("ignore remainder", bus.remainder, 32'd2);
    $display("op ignore: 100/7 with 9/3 pulse -> q=%h r=%h", bus.quotient, bus.remainder);

    // Reset in the middle of RUN aborts immediately, no done afterwards.
    @(negedge clk);
    bus.dividend = 32'd1000; bus.divisor = 32'd3; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrun busy", {31'd0, bus.busy}, 32'd0);
    chk("midrun done", {31'd0, bus.done}, 32'd0);
    chk("midrun quotient", bus.quotient, 32'd0);
    chk("midrun remainder", bus.remainder, 32'd0);
    chk("midrun div_zero", {31'd0, bus.div_zero}, 32'd0);
    $display("op midrun_reset: outputs q=%h r=%h busy=%0d", bus.quotient, bus.remainder, bus.busy);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    chk("midrun no_done", 32'(done_cnt), 32'd0);

    // First start after reset is accepted at the next edge.
    do_div("post_reset", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);

    // Back-to-back with start held high.
    @(negedge clk);
    bus.sign = 1'b0; bus.dividend = 32'hFFFF_FFFF; bus.divisor = 32'd1; bus.start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    bus.dividend = 32'd0; bus.divisor = 32'd3;
    wait_done(100, "b2b first");
    t1 = cyc;
    chk("b2b first latency", 32'(t1 - e0), 32'd32);
    chk("b2b first quotient", bus.quotient, 32'hFFFF_FFFF);
    chk("b2b first remainder", bus.remainder, 32'd0);
    $display("op b2b_first: q=%h r=%h", bus.quotient, bus.remainder);
    @(posedge clk);
    #1;
    wait_done(100, "b2b second");
    t2 = cyc;
    bus.start = 1'b0;
    chk("b2b spacing", 32'(t2 - t1), 32'd34);
    chk("b2b second quotient", bus.quotient, 32'd0);
    chk("b2b second remainder", bus.remainder, 32'd0);
    $display("op b2b_second: q=%h r=%h spacing=%0d", bus.quotient, bus.remainder, t2 - t1);
    repeat (2) @(posedge clk);

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      rs   = 1'($urandom_range(0, 1));
      ra   = $urandom;
      mode = $urandom_range(0, 9);
      if (mode == 0)      rb = 32'd0;
      else if (mode < 5)  rb = 32'($urandom_range(1, 20));
      else                rb = $urandom;
      if (rs && mode > 2 && mode < 5) rb = 32'd0 - rb;
      ref_div(rs, ra, rb, eq, er, edz);
      do_div($sformatf("rand%0d", i), rs, ra, rb, eq, er, edz);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
